// File: rtl/bomb_matrix_fuse_ctrl.sv
// bomb_matrix_fuse_ctrl: fuse/bomb animator for a multiplexed ROWSxCOLS red/green
// LED matrix, with start/defuse run control and a status readout.
//
// Ports:
//   clk        system clock (also the scan clock)
//   rst_n      synchronous active-low reset
//   start      level-sampled; begins burning from IDLE or DEFUSED
//   defuse     level-sampled; stops the burn while BURNING
//   hang       row select, active low, one-hot-zero (row 0 is the MSB)
//   red, gre   column drive, active high
//   state_o    0=IDLE 1=BURNING 2=EXPLODED 3=DEFUSED
//   fuse_left  unburnt fuse rows
//
// Optional feature: define BOMB_AUTO_RESTART_EN to go from EXPLODED straight back
// to BURNING (free-running demo loop) instead of to IDLE.
module bomb_matrix_fuse_ctrl #(
    parameter int unsigned ROWS          = 8,
    parameter int unsigned COLS          = 8,
    parameter int unsigned FUSE_ROWS     = 4,
    parameter int unsigned SCAN_DIV      = 1,
    parameter int unsigned TICK_DIV      = 5000,
    parameter int unsigned EXPLODE_TICKS = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               defuse,
    output logic [ROWS-1:0]                    hang,
    output logic [COLS-1:0]                    red,
    output logic [COLS-1:0]                    gre,
    output logic [1:0]                         state_o,
    output logic [$clog2(FUSE_ROWS+1)-1:0]     fuse_left
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned EW = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;
    localparam int unsigned FW = $clog2(FUSE_ROWS + 1);
    localparam int unsigned C0 = COLS / 2 - 1;
    localparam int unsigned C1 = COLS / 2;

    // Two centre columns, and the pair just outside them (bomb body sides).
    localparam logic [COLS-1:0] MID  = (COLS'(1) << C0) | (COLS'(1) << C1);
    localparam logic [COLS-1:0] RING = (COLS'(1) << (C0 - 1)) | (COLS'(1) << (C1 + 1));

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BURNING  = 2'd1,
        ST_EXPLODED = 2'd2,
        ST_DEFUSED  = 2'd3
    } state_t;

    state_t          state;
    logic [RW-1:0]   row;
    logic [SW-1:0]   sdiv;
    logic [TW-1:0]   tcnt;
    logic [FW-1:0]   burnt;
    logic [EW-1:0]   ecnt;
    logic            flash;

    logic            timing_c;
    logic            tick_c;
    logic [COLS-1:0] shape_c;
    logic [COLS-1:0] row_red_c;
    logic [COLS-1:0] row_gre_c;
    logic [ROWS-1:0] row_sel_c;

    assign state_o = state;

    // Tick generation and the pattern for the row currently being scanned.
    always_comb begin
        timing_c  = (state == ST_BURNING) || (state == ST_EXPLODED);
        tick_c    = timing_c && (tcnt == TW'(TICK_DIV - 1));
        shape_c   = ((row == RW'(FUSE_ROWS)) || (row == RW'(ROWS - 1))) ? MID : RING;
        row_red_c = '0;
        row_gre_c = '0;
        if (state == ST_EXPLODED) begin
            row_red_c = flash ? '0 : '1;
        end else if (32'(row) < FUSE_ROWS) begin
            if (32'(row) >= 32'(burnt)) begin
                row_red_c = MID;
                row_gre_c = MID;
            end
        end else if (state == ST_DEFUSED) begin
            row_gre_c = shape_c;
        end else begin
            row_red_c = shape_c;
        end
        row_sel_c = ~(ROWS'(1) << (RW'(ROWS - 1) - row));
    end

    // Scan, tick counter and game FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            row       <= '0;
            sdiv      <= '0;
            tcnt      <= '0;
            burnt     <= '0;
            ecnt      <= '0;
            flash     <= 1'b0;
            hang      <= '1;
            red       <= '0;
            gre       <= '0;
            fuse_left <= FW'(FUSE_ROWS);
        end else begin
            if (sdiv == SW'(SCAN_DIV - 1)) begin
                sdiv <= '0;
                row  <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
            end else begin
                sdiv <= sdiv + SW'(1);
            end
            hang <= row_sel_c;
            red  <= row_red_c;
            gre  <= row_gre_c;

            // Free-runs in timed states; state entries below force it back to 0.
            tcnt <= (timing_c && !tick_c) ? tcnt + TW'(1) : '0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_BURNING;
                        burnt     <= '0;
                        fuse_left <= FW'(FUSE_ROWS);
                        tcnt      <= '0;
                    end
                end
                ST_BURNING: begin
                    // Defuse beats a coincident tick, freezing burnt.
                    if (defuse) begin
                        state <= ST_DEFUSED;
                        tcnt  <= '0;
                    end else if (tick_c) begin
                        if (burnt == FW'(FUSE_ROWS)) begin
                            state <= ST_EXPLODED;
                            ecnt  <= '0;
                            flash <= 1'b0;
                        end else begin
                            burnt     <= burnt + FW'(1);
                            fuse_left <= FW'(FUSE_ROWS) - burnt - FW'(1);
                        end
                    end
                end
                ST_EXPLODED: begin
                    if (tick_c) begin
                        if (ecnt == EW'(EXPLODE_TICKS - 1)) begin
`ifdef BOMB_AUTO_RESTART_EN
                            state <= ST_BURNING;
`else
                            state <= ST_IDLE;
`endif
                            burnt     <= '0;
                            fuse_left <= FW'(FUSE_ROWS);
                        end else begin
                            ecnt  <= ecnt + EW'(1);
                        end
                        flash <= ~flash;
                    end
                end
                ST_DEFUSED: begin
                    if (start) begin
                        state     <= ST_BURNING;
                        burnt     <= '0;
                        fuse_left <= FW'(FUSE_ROWS);
                        tcnt      <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_matrix_fuse_ctrl.sv
// Directed self-checking bench for bomb_matrix_fuse_ctrl (8x8, FUSE_ROWS=4,
// SCAN_DIV=1, TICK_DIV=4, EXPLODE_TICKS=4).
module tb_bomb_matrix_fuse_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       defuse;
    logic [7:0] hang;
    logic [7:0] red;
    logic [7:0] gre;
    logic [1:0] state_o;
    logic [2:0] fuse_left;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    bomb_matrix_fuse_ctrl #(
        .ROWS(8), .COLS(8), .FUSE_ROWS(4), .SCAN_DIV(1), .TICK_DIV(4), .EXPLODE_TICKS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .defuse(defuse),
        .hang(hang), .red(red), .gre(gre), .state_o(state_o), .fuse_left(fuse_left)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; defuse = 1'b0;
        clk_n(2);
        chk_cnt++; if (hang !== 8'hFF) $display("FAIL reset_hang: got %h want ff", hang); else pass_cnt++;
        chk_cnt++; if (red !== 8'h00) $display("FAIL reset_red: got %h want 00", red); else pass_cnt++;
        chk_cnt++; if (gre !== 8'h00) $display("FAIL reset_gre: got %h want 00", gre); else pass_cnt++;
        chk_cnt++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_o); else pass_cnt++;
        chk_cnt++; if (fuse_left !== 3'd4) $display("FAIL reset_fuse_left: got %0d want 4", fuse_left); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    // One full IDLE frame right after reset release: rows 0..7 in order.
    task automatic test_scan_idle;
        logic [7:0] exp_red [8] = '{8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h24, 8'h24, 8'h18};
        logic [7:0] exp_gre [8] = '{8'h18, 8'h18, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] eh;
        for (int i = 0; i < 8; i++) begin
            clk_n(1);
            eh = ~(8'h80 >> i);
            chk_cnt++; if (hang !== eh) $display("FAIL idle_hang[%0d]: got %h want %h", i, hang, eh); else pass_cnt++;
            chk_cnt++; if (red !== exp_red[i]) $display("FAIL idle_red[%0d]: got %h want %h", i, red, exp_red[i]); else pass_cnt++;
            chk_cnt++; if (gre !== exp_gre[i]) $display("FAIL idle_gre[%0d]: got %h want %h", i, gre, exp_gre[i]); else pass_cnt++;
        end
        chk_cnt++; if (state_o !== 2'd0) $display("FAIL idle_state: got %0d want 0", state_o); else pass_cnt++;
    endtask

    // Start sampled on edge 9 (S); ticks land on S+4, S+8, ... and row k shows at edge k+1 mod 8.
    task automatic test_burn;
        logic [7:0] eh;
        start = 1'b1;
        clk_n(1);
        start = 1'b0;
        chk_cnt++; if (state_o !== 2'd1) $display("FAIL burn_state: got %0d want 1", state_o); else pass_cnt++;
        chk_cnt++; if (fuse_left !== 3'd4) $display("FAIL burn_fuse0: got %0d want 4", fuse_left); else pass_cnt++;
        clk_n(4);
        chk_cnt++; if (fuse_left !== 3'd3) $display("FAIL burn_fuse1: got %0d want 3", fuse_left); else pass_cnt++;
        clk_n(4);
        chk_cnt++; if (fuse_left !== 3'd2) $display("FAIL burn_fuse2: got %0d want 2", fuse_left); else pass_cnt++;
        chk_cnt++; if (hang !== 8'h7F) $display("FAIL burn_row0_hang: got %h want 7f", hang); else pass_cnt++;
        chk_cnt++; if (red !== 8'h00 || gre !== 8'h00)
            $display("FAIL burn_row0_blank: got red %h gre %h want 00 00", red, gre); else pass_cnt++;
        clk_n(8);
        chk_cnt++; if (fuse_left !== 3'd0) $display("FAIL burn_fuse4: got %0d want 0", fuse_left); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) clk_n(1);
            eh = ~(8'h80 >> i);
            chk_cnt++; if (hang !== eh || red !== 8'h00 || gre !== 8'h00)
                $display("FAIL burnt_row%0d: got hang %h red %h gre %h want %h 00 00", i, hang, red, gre, eh);
            else pass_cnt++;
        end
        chk_cnt++; if (state_o !== 2'd1) $display("FAIL burn_allburnt_state: got %0d want 1", state_o); else pass_cnt++;
        clk_n(1);
        chk_cnt++; if (state_o !== 2'd2) $display("FAIL burn_explode_state: got %0d want 2", state_o); else pass_cnt++;
        chk_cnt++; if (hang !== 8'hF7 || red !== 8'h18 || gre !== 8'h00)
            $display("FAIL burn_row4: got hang %h red %h gre %h want f7 18 00", hang, red, gre); else pass_cnt++;
    endtask

    // Four 4-cycle flash phases: lit, dark, lit, dark; then the exit state.
    task automatic test_explode;
        logic [7:0] er;
        logic [1:0] exit_state;
`ifdef BOMB_AUTO_RESTART_EN
        exit_state = 2'd1;
`else
        exit_state = 2'd0;
`endif
        for (int k = 0; k < 16; k++) begin
            clk_n(1);
            er = ((k / 4) % 2 == 1) ? 8'h00 : 8'hFF;
            chk_cnt++; if (red !== er || gre !== 8'h00)
                $display("FAIL explode_frame[%0d]: got red %h gre %h want %h 00", k, red, gre, er); else pass_cnt++;
            if (k < 15) begin
                chk_cnt++; if (state_o !== 2'd2) $display("FAIL explode_state[%0d]: got %0d want 2", k, state_o); else pass_cnt++;
            end
        end
        chk_cnt++; if (state_o !== exit_state) $display("FAIL explode_exit_state: got %0d want %0d", state_o, exit_state); else pass_cnt++;
        chk_cnt++; if (fuse_left !== 3'd4) $display("FAIL explode_exit_fuse: got %0d want 4", fuse_left); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burn;
        start = 1'b1;
        clk_n(1);
        start = 1'b0;
        clk_n(5);
        chk_cnt++; if (state_o !== 2'd1) $display("FAIL midburn_pre_state: got %0d want 1", state_o); else pass_cnt++;
        rst_n = 1'b0;
        clk_n(1);
        rst_n = 1'b1;
        chk_cnt++; if (hang !== 8'hFF || red !== 8'h00 || gre !== 8'h00)
            $display("FAIL midburn_outputs: got hang %h red %h gre %h want ff 00 00", hang, red, gre); else pass_cnt++;
        chk_cnt++; if (state_o !== 2'd0) $display("FAIL midburn_state: got %0d want 0", state_o); else pass_cnt++;
        chk_cnt++; if (fuse_left !== 3'd4) $display("FAIL midburn_fuse: got %0d want 4", fuse_left); else pass_cnt++;
    endtask

    // start and defuse together in IDLE: start first, defuse on the following edge.
    task automatic test_start_defuse_same;
        start = 1'b1; defuse = 1'b1;
        clk_n(1);
        start = 1'b0;
        chk_cnt++; if (state_o !== 2'd1) $display("FAIL both_first_state: got %0d want 1", state_o); else pass_cnt++;
        clk_n(1);
        defuse = 1'b0;
        chk_cnt++; if (state_o !== 2'd3) $display("FAIL both_second_state: got %0d want 3", state_o); else pass_cnt++;
        chk_cnt++; if (fuse_left !== 3'd4) $display("FAIL both_fuse: got %0d want 4", fuse_left); else pass_cnt++;
        rst_n = 1'b0;
        clk_n(1);
        rst_n = 1'b1;
    endtask

    // Start on edge 1 after reset (S); defuse coincides with the tick on S+12 at fuse_left=2.
    task automatic test_defuse;
        logic [7:0] rows  [8] = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        logic [7:0] exp_r [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00};
        logic [7:0] exp_g [8] = '{8'h24, 8'h24, 8'h18, 8'h00, 8'h00, 8'h18, 8'h18, 8'h18};
        logic [7:0] eh;
        start = 1'b1;
        clk_n(1);
        start = 1'b0;
        clk_n(8);
        chk_cnt++; if (fuse_left !== 3'd2) $display("FAIL defuse_pre_fuse: got %0d want 2", fuse_left); else pass_cnt++;
        clk_n(3);
        defuse = 1'b1;
        clk_n(1);
        defuse = 1'b0;
        chk_cnt++; if (state_o !== 2'd3) $display("FAIL defuse_state: got %0d want 3", state_o); else pass_cnt++;
        chk_cnt++; if (fuse_left !== 3'd2) $display("FAIL defuse_fuse: got %0d want 2", fuse_left); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            clk_n(1);
            eh = ~(8'h80 >> rows[i]);
            chk_cnt++; if (hang !== eh || red !== exp_r[i] || gre !== exp_g[i])
                $display("FAIL defused_row%0d: got hang %h red %h gre %h want %h %h %h",
                         rows[i], hang, red, gre, eh, exp_r[i], exp_g[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (state_o !== 2'd3 || fuse_left !== 3'd2)
            $display("FAIL defuse_hold: got state %0d fuse %0d want 3 2", state_o, fuse_left); else pass_cnt++;
        start = 1'b1;
        clk_n(1);
        start = 1'b0;
        chk_cnt++; if (state_o !== 2'd1) $display("FAIL restart_state: got %0d want 1", state_o); else pass_cnt++;
        chk_cnt++; if (fuse_left !== 3'd4) $display("FAIL restart_fuse: got %0d want 4", fuse_left); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; defuse = 1'b0;
        test_reset();
        test_scan_idle();
        test_burn();
        test_explode();
        test_reset_mid_burn();
        test_start_defuse_same();
        test_defuse();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
